// File: rtl/axis_fifo_ctrl.sv
// axis_fifo_ctrl: control half of an AXI-Stream FIFO.
// Owns the write/read pointers, full/empty state and the valid bit of every
// registered output stage. It drives the enable/address side of a 1R1W sync
// memory followed by pipeline_output_p output registers; data never passes here.
// Optional level reporting (count_o, almost_full_o) is built only when the
// macro AXIS_FIFO_CTRL_LEVEL_EN is defined; otherwise both outputs tie to 0.
module axis_fifo_ctrl #(
    parameter int els_p                = 16,
    parameter int pipeline_output_p    = 1,
    parameter int almost_full_thresh_p = els_p - 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             s_axis_tvalid_i,
    output logic                             s_axis_tready_o,
    output logic                             m_axis_tvalid_o,
    input  logic                             m_axis_tready_i,
    output logic                             w_v_o,
    output logic [$clog2(els_p)-1:0]         w_addr_o,
    output logic                             r_v_o,
    output logic [$clog2(els_p)-1:0]         r_addr_o,
    output logic                             output_ready_o,
    output logic [pipeline_output_p-1:0]     valid_pipe_reg_o,
    output logic [$clog2(els_p+1)-1:0]       count_o,
    output logic                             almost_full_o
);

    localparam int addr_w_lp  = $clog2(els_p);
    localparam int ptr_w_lp   = addr_w_lp + 1;
    localparam int count_w_lp = $clog2(els_p + 1);

    // Marks the last output stage, which can only move when downstream accepts.
    localparam logic [pipeline_output_p-1:0] last_stage_lp =
        pipeline_output_p'(1) << (pipeline_output_p - 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp-1:0]          wr_ptr_r;
    logic [ptr_w_lp-1:0]          rd_ptr_r;
    logic                         empty;
    logic                         full;
    logic                         w_v;
    logic                         r_v;

    logic [pipeline_output_p-1:0] valid_r;
    logic [pipeline_output_p-1:0] valid_n;
    logic [pipeline_output_p-1:0] take;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[addr_w_lp-1:0] == rd_ptr_r[addr_w_lp-1:0]) &&
                   (wr_ptr_r[addr_w_lp] != rd_ptr_r[addr_w_lp]);

    // Stage j may hand its beat on when downstream accepts or stage j+1 is empty;
    // the last stage sees a virtual always-full successor so it waits for tready.
    assign take = {pipeline_output_p{m_axis_tready_i}} |
                  ~((valid_r >> 1) | last_stage_lp);

    assign w_v = s_axis_tvalid_i && !full;
    assign r_v = !empty && (!valid_r[0] || take[0]);

    assign s_axis_tready_o  = !full;
    assign w_v_o            = w_v;
    assign w_addr_o         = wr_ptr_r[addr_w_lp-1:0];
    assign r_v_o            = r_v;
    assign r_addr_o         = rd_ptr_r[addr_w_lp-1:0];
    assign output_ready_o   = m_axis_tready_i;
    assign valid_pipe_reg_o = valid_r;
    assign m_axis_tvalid_o  = valid_r[pipeline_output_p-1];

    // Next valid state: a stage keeps its beat unless it moves on, and picks up
    // the beat of the previous stage (or a fresh memory read for stage 0).
    always_comb begin
        valid_n    = valid_r;
        valid_n[0] = r_v || (valid_r[0] && !take[0]);
        for (int j = 1; j < pipeline_output_p; j++) begin
            valid_n[j] = (valid_r[j] && !take[j]) || (valid_r[j-1] && take[j-1]);
        end
    end

    // Pointer registers; each wraps modulo 2*els_p through the extra bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (w_v) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            if (r_v) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
        end
    end

    // Output-stage valid bits; reset drops any beat in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) valid_r <= '0;
        else         valid_r <= valid_n;
    end

`ifdef AXIS_FIFO_CTRL_LEVEL_EN
    localparam logic [count_w_lp-1:0] thresh_lp = count_w_lp'(almost_full_thresh_p);

    logic [count_w_lp-1:0] count_r;
    logic [count_w_lp-1:0] count_n;
    logic                  almost_full_r;

    // Occupancy tracks wr_ptr - rd_ptr by applying the same write/read events.
    assign count_n = count_r + count_w_lp'(w_v) - count_w_lp'(r_v);

    // Level registers update on the same edge as the pointers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r       <= '0;
            almost_full_r <= 1'b0;
        end else begin
            count_r       <= count_n;
            almost_full_r <= (count_n >= thresh_lp);
        end
    end

    assign count_o       = count_r;
    assign almost_full_o = almost_full_r;
`else
    logic unused_level_cfg;

    assign unused_level_cfg = (almost_full_thresh_p != 0);
    assign count_o          = '0;
    assign almost_full_o    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Self-checking bench for axis_fifo_ctrl (els_p=8, pipeline_output_p=2).
// A queue/slot model of the FIFO predicts every control output each cycle;
// a short directed opening pins a few hand-computed values.
module tb_axis_fifo_ctrl;

    localparam int ELS = 8;
    localparam int P   = 2;
    localparam int THR = ELS - 2;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         s_axis_tvalid_i = 1'b0;
    logic         s_axis_tready_o;
    logic         m_axis_tvalid_o;
    logic         m_axis_tready_i = 1'b0;
    logic         w_v_o;
    logic [2:0]   w_addr_o;
    logic         r_v_o;
    logic [2:0]   r_addr_o;
    logic         output_ready_o;
    logic [P-1:0] valid_pipe_reg_o;
    logic [3:0]   count_o;
    logic         almost_full_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    axis_fifo_ctrl #(
        .els_p               (ELS),
        .pipeline_output_p   (P),
        .almost_full_thresh_p(THR)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .w_v_o           (w_v_o),
        .w_addr_o        (w_addr_o),
        .r_v_o           (r_v_o),
        .r_addr_o        (r_addr_o),
        .output_ready_o  (output_ready_o),
        .valid_pipe_reg_o(valid_pipe_reg_o),
        .count_o         (count_o),
        .almost_full_o   (almost_full_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mem_q holds the sequence numbers of entries still in memory; slot[j] holds
    // the sequence number sitting in output stage j (-1 when empty).
    int mem_q[$];
    int slot[P];
    int wr_cnt;
    int rd_cnt;

    always @(negedge clk_i) begin : model_compare
        bit full_m;
        bit wv_m;
        bit rv_m;
        bit take_m[P];
        int nslot[P];
        int exp_vpr;
        int exp_cnt;
        int exp_af;
        if (reset_i) begin
            mem_q.delete();
            for (int j = 0; j < P; j++) slot[j] = -1;
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            full_m = (mem_q.size() == ELS);
            wv_m   = s_axis_tvalid_i && !full_m;
            for (int j = 0; j < P; j++) begin
                if (j == P - 1) take_m[j] = m_axis_tready_i;
                else            take_m[j] = m_axis_tready_i || (slot[j+1] < 0);
            end
            rv_m = (mem_q.size() > 0) && ((slot[0] < 0) || take_m[0]);
            exp_vpr = 0;
            for (int j = 0; j < P; j++) if (slot[j] >= 0) exp_vpr |= (1 << j);
`ifdef AXIS_FIFO_CTRL_LEVEL_EN
            exp_cnt = mem_q.size();
            exp_af  = (mem_q.size() >= THR) ? 1 : 0;
`else
            exp_cnt = 0;
            exp_af  = 0;
`endif
            chk("s_axis_tready_o", int'(s_axis_tready_o), int'(!full_m));
            chk("w_v_o", int'(w_v_o), int'(wv_m));
            chk("w_addr_o", int'(w_addr_o), wr_cnt % ELS);
            chk("r_v_o", int'(r_v_o), int'(rv_m));
            chk("r_addr_o", int'(r_addr_o), rd_cnt % ELS);
            chk("valid_pipe_reg_o", int'(valid_pipe_reg_o), exp_vpr);
            chk("m_axis_tvalid_o", int'(m_axis_tvalid_o), (slot[P-1] >= 0) ? 1 : 0);
            chk("output_ready_o", int'(output_ready_o), int'(m_axis_tready_i));
            chk("count_o", int'(count_o), exp_cnt);
            chk("almost_full_o", int'(almost_full_o), exp_af);

            for (int j = 0; j < P; j++) nslot[j] = -1;
            for (int j = P - 1; j >= 0; j--) begin
                if (slot[j] >= 0) begin
                    if (take_m[j]) begin
                        if (j < P - 1) nslot[j+1] = slot[j];
                    end else begin
                        nslot[j] = slot[j];
                    end
                end
            end
            if (rv_m) begin
                nslot[0] = mem_q.pop_front();
                rd_cnt++;
            end
            if (wv_m) begin
                mem_q.push_back(wr_cnt);
                wr_cnt++;
            end
            for (int j = 0; j < P; j++) slot[j] = nslot[j];
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit r, input bit rst);
        @(posedge clk_i);
        #1;
        reset_i         = rst;
        s_axis_tvalid_i = v;
        m_axis_tready_i = r;
    endtask

    task automatic look();
        @(negedge clk_i);
        #1;
    endtask

    int pv_tab[8] = '{50, 100, 100, 30, 90, 70, 100, 20};
    int pr_tab[8] = '{50, 100, 10, 90, 40, 70, -1, 100};

    initial begin
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Reset state
        look();
        chk("rst_tready", int'(s_axis_tready_o), 1);
        chk("rst_mvalid", int'(m_axis_tvalid_o), 0);
        chk("rst_vpr", int'(valid_pipe_reg_o), 0);
        chk("rst_count", int'(count_o), 0);

        // Single write, then watch it travel through both stages
        drive(1, 0, 0); look();
        chk("w0_wv", int'(w_v_o), 1);
        chk("w0_waddr", int'(w_addr_o), 0);
        chk("w0_rv", int'(r_v_o), 0);
        drive(0, 0, 0); look();
        chk("c1_rv", int'(r_v_o), 1);
        chk("c1_raddr", int'(r_addr_o), 0);
        chk("c1_mvalid", int'(m_axis_tvalid_o), 0);
        drive(0, 0, 0); look();
        chk("c2_vpr", int'(valid_pipe_reg_o), 1);
        chk("c2_mvalid", int'(m_axis_tvalid_o), 0);
        drive(0, 0, 0); look();
        chk("c3_vpr", int'(valid_pipe_reg_o), 2);
        chk("c3_mvalid", int'(m_axis_tvalid_o), 1);
        drive(0, 0, 0); look();
        chk("c4_mvalid_held", int'(m_axis_tvalid_o), 1);

        // Fill with downstream stalled: one more beat lands in stage 0, 8 in memory
        repeat (12) drive(1, 0, 0);
        look();
        chk("full_tready", int'(s_axis_tready_o), 0);
        chk("full_wv", int'(w_v_o), 0);
        chk("full_vpr", int'(valid_pipe_reg_o), 3);
`ifdef AXIS_FIFO_CTRL_LEVEL_EN
        chk("full_count", int'(count_o), 8);
        chk("full_af", int'(almost_full_o), 1);
`endif

        // One accept while full: tready stays low this cycle, rises the next
        drive(1, 1, 0); look();
        chk("drain_tready", int'(s_axis_tready_o), 0);
        chk("drain_rv", int'(r_v_o), 1);
        chk("drain_raddr", int'(r_addr_o), 2);
        drive(1, 0, 0); look();
        chk("after_tready", int'(s_axis_tready_o), 1);
        chk("after_wv", int'(w_v_o), 1);
        chk("after_waddr_wrap", int'(w_addr_o), 2);

        // Reset with a full pipe discards everything
        drive(0, 0, 1);
        drive(0, 0, 0); look();
        chk("rst2_vpr", int'(valid_pipe_reg_o), 0);
        chk("rst2_mvalid", int'(m_axis_tvalid_o), 0);
        chk("rst2_tready", int'(s_axis_tready_o), 1);
        chk("rst2_rv", int'(r_v_o), 0);
        chk("rst2_count", int'(count_o), 0);

        // Randomized phases; pr=-1 means tready toggles every cycle
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 400; c++) begin
                bit v;
                bit r;
                bit rst;
                v   = ($urandom_range(99) < pv_tab[ph]);
                if (pr_tab[ph] < 0) r = c[0];
                else                r = ($urandom_range(99) < pr_tab[ph]);
                rst = ($urandom_range(299) == 0);
                drive(v, r, rst);
            end
        end

        drive(0, 0, 0);
        @(posedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
